// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the iomem valid/ready bus.
// It forwards one granted access at a time to the slave fabric. A watchdog
// completes stalled accesses with ERR_DATA and records the failure.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        bus_err,
    output logic [31:0] err_addr,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t      state, state_nxt;
    logic        last_grant, grant_nxt;
    logic [31:0] wdt;
    logic        granted;
    logic        timeout_hit;
    logic        done;

    assign granted     = (state == GNT0) || (state == GNT1);
    assign timeout_hit = (TIMEOUT != 0) && s_valid && (wdt == TIMEOUT - 1) && !s_ready;
    // Reset wins over a completion in the same cycle, so an aborted access never responds.
    assign done        = s_valid && (s_ready || timeout_hit) && !reset;

    // Request mux: forward the granted master onto the slave bus
    always_comb begin
        s_valid = 1'b0;
        s_wstrb = '0;
        s_addr  = '0;
        s_wdata = '0;
        case (state)
            GNT0: begin
                s_valid = m0_valid;
                s_wstrb = m0_wstrb;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
            end
            GNT1: begin
                s_valid = m1_valid;
                s_wstrb = m1_wstrb;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
            end
            default: ;
        endcase
    end

    // Next-state, round-robin arbitration and completion responses
    always_comb begin
        state_nxt = state;
        grant_nxt = last_grant;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        case (state)
            IDLE: begin
                if (m0_valid && (!m1_valid || last_grant)) begin
                    state_nxt = GNT0;
                    grant_nxt = 1'b0;
                end else if (m1_valid) begin
                    state_nxt = GNT1;
                    grant_nxt = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_valid) begin
                    state_nxt = IDLE;
                end else if (done) begin
                    state_nxt = IDLE;
                    m0_ready  = 1'b1;
                    m0_rdata  = s_ready ? s_rdata : ERR_DATA;
                end
            end
            GNT1: begin
                if (!m1_valid) begin
                    state_nxt = IDLE;
                end else if (done) begin
                    state_nxt = IDLE;
                    m1_ready  = 1'b1;
                    m1_rdata  = s_ready ? s_rdata : ERR_DATA;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, grant history and watchdog registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wdt        <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= grant_nxt;
            if (!granted) begin
                wdt <= '0;
            end else if (s_valid && !s_ready) begin
                wdt <= wdt + 32'd1;
            end
        end
    end

    // Error reporting: registered pulse, last failing address, saturating count
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err   <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            bus_err <= timeout_hit;
            if (timeout_hit) begin
                err_addr <= s_addr;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Scoreboard bench for iomem_arbiter: the stimulus thread pushes expected
// responses, and a negedge monitor pops and compares them on every ready.
module tb_iomem_arbiter;

    typedef struct packed {
        logic        m;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready, bus_err;
    logic [31:0] s_addr, s_wdata, s_rdata, err_addr;
    logic [7:0]  err_count;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t exp_q[$];
    exp_t e;

    iomem_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .bus_err(bus_err), .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic m, input logic [31:0] d);
        exp_t x;
        x.m    = m;
        x.data = d;
        exp_q.push_back(x);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    // One master-0 access that the watchdog (TIMEOUT=4) terminates
    task automatic run_timeout(input logic [31:0] addr);
        m0_valid = 1'b1; m0_addr = addr; m0_wstrb = 4'h0; s_ready = 1'b0;
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) push(1'b0, 32'hDEAD_BEEF);
            step();
        end
        m0_valid = 1'b0;
    endtask

    // Monitor: every completion must match the oldest expected response
    always @(negedge clk) begin
        if (!reset) begin
            if (m0_ready || m1_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_ready: m0_ready=%b m1_ready=%b expected none at %0t",
                             m0_ready, m1_ready, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_both_ready", 32'(m0_ready & m1_ready), 32'd0);
                    chk("resp_master", 32'(m1_ready), 32'(e.m));
                    chk("resp_rdata", m1_ready ? m1_rdata : m0_rdata, e.data);
                end
            end
            if (!m0_ready) chk("m0_rdata_idle_zero", m0_rdata, 32'd0);
            if (!m1_ready) chk("m1_rdata_idle_zero", m1_rdata, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: bench did not finish, got timeout expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
        m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
        s_rdata = '0;
        do_reset();
        #1;
        // Reset state
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);

        // Single read: s_valid one cycle after request, s_ready two cycles after request
        m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wstrb = 4'h0;
        #1;
        chk("rd_latency_same_cycle", 32'(s_valid), 32'd0);
        step();
        chk("rd_s_valid", 32'(s_valid), 32'd1);
        chk("rd_s_addr", s_addr, 32'h0300_0000);
        chk("rd_s_wstrb", 32'(s_wstrb), 32'd0);
        step();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        push(1'b0, 32'h1234_5678);
        #1;
        chk("rd_m0_ready", 32'(m0_ready), 32'd1);
        step();
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        chk("rd_bubble", 32'(s_valid), 32'd0);

        // Contention after reset: 0,1,0,1 with a bubble between grants
        do_reset();
        m0_addr = 32'h0300_0100; m1_addr = 32'h0400_0200;
        s_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            m0_valid = (i < 6);
            m1_valid = (i < 8);
            s_rdata  = 32'h0000_1000 + 32'(i);
            if (i % 4 == 1) push(1'b0, 32'h0000_1000 + 32'(i));
            if (i % 4 == 3) push(1'b1, 32'h0000_1000 + 32'(i));
            #1;
            chk("rr_s_valid", 32'(s_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 4 == 1) chk("rr_s_addr_m0", s_addr, 32'h0300_0100);
            if (i % 4 == 3) chk("rr_s_addr_m1", s_addr, 32'h0400_0200);
            step();
        end
        s_ready = 1'b0;

        // Timeout: m1 write, slave never answers
        m1_valid = 1'b1; m1_addr = 32'h0400_0010; m1_wstrb = 4'hF; m1_wdata = 32'hA5A5_0001;
        step();
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) push(1'b1, 32'hDEAD_BEEF);
            #1;
            chk("to_s_valid", 32'(s_valid), 32'd1);
            if (k == 1) begin
                chk("to_s_addr", s_addr, 32'h0400_0010);
                chk("to_s_wstrb", 32'(s_wstrb), 32'hF);
                chk("to_s_wdata", s_wdata, 32'hA5A5_0001);
            end
            chk("to_m1_ready", 32'(m1_ready), (k == 4) ? 32'd1 : 32'd0);
            chk("to_no_err_yet", 32'(bus_err), 32'd0);
            step();
        end
        m1_valid = 1'b0;
        #1;
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_err_addr", err_addr, 32'h0400_0010);
        chk("to_err_count", 32'(err_count), 32'd1);
        chk("to_s_valid_drop", 32'(s_valid), 32'd0);
        step();
        chk("to_bus_err_pulse", 32'(bus_err), 32'd0);

        // Race: s_ready on the exact timeout cycle wins
        m0_valid = 1'b1; m0_addr = 32'h0300_0020; m0_wstrb = 4'h0;
        step();
        repeat (3) step();
        s_ready = 1'b1; s_rdata = 32'hCAFE_F00D;
        push(1'b0, 32'hCAFE_F00D);
        step();
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        chk("race_bus_err", 32'(bus_err), 32'd0);
        chk("race_err_count", 32'(err_count), 32'd1);
        chk("race_err_addr", err_addr, 32'h0400_0010);

        // Saturation: 260 timeouts in total
        for (int i = 2; i <= 260; i++) begin
            run_timeout(32'h0500_0000 + 32'(i) * 32'd4);
            #1;
            if (i == 254) chk("sat_count_254", 32'(err_count), 32'hFE);
            if (i == 255) chk("sat_count_255", 32'(err_count), 32'hFF);
            if (i == 260) begin
                chk("sat_count_260", 32'(err_count), 32'hFF);
                chk("sat_err_addr", err_addr, 32'h0500_0410);
                chk("sat_bus_err", 32'(bus_err), 32'd1);
            end
        end
        step();

        // Reset mid-transaction: no response, then lone m1 is granted
        m0_valid = 1'b1; m0_addr = 32'h0300_0030;
        step();
        #1;
        chk("mid_gnt0", 32'(s_valid), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_valid = 1'b0;
        m1_valid = 1'b1; m1_addr = 32'h0400_0040; m1_wstrb = 4'h0;
        #1;
        chk("mid_s_valid_low", 32'(s_valid), 32'd0);
        chk("mid_no_m0_ready", 32'(m0_ready), 32'd0);
        chk("mid_err_count_cleared", 32'(err_count), 32'd0);
        step();
        chk("mid_m1_grant", 32'(s_valid), 32'd1);
        chk("mid_m1_addr", s_addr, 32'h0400_0040);
        s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
        push(1'b1, 32'h0BAD_F00D);
        step();
        m1_valid = 1'b0; s_ready = 1'b0;
        repeat (2) step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
